// File: rtl/fifo_pkg.sv
// Shared defaults and FSM encoding for the FIFO reader block.
package fifo_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDepth = 32;
    localparam int unsigned DefUseW  = $clog2(DefDepth) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StEspera,
        StLectura,
        StVaciado
    } lector_state_t;

endpackage

// File: rtl/fifo_lector_if.sv
// FIFO-side and downstream-side signals of the reader, grouped for direct hookup.
interface fifo_lector_if
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned USE_W = DefUseW
);

    logic [WIDTH-1:0] data_out;
    logic [USE_W-1:0] use_dw;
    logic             f_empty_n;
    logic             read;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_last;

    modport master (
        input  data_out, use_dw, f_empty_n, tx_ready,
        output read, tx_data, tx_valid, tx_last
    );

    modport slave (
        output data_out, use_dw, f_empty_n, tx_ready,
        input  read, tx_data, tx_valid, tx_last
    );

endinterface

// File: rtl/fifo_lector_skid.sv
// Two-entry output buffer; the head stays put while it is not popped.
module fifo_lector_skid
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             pop_ok;

    assign pop_ok = pop && (count_q != 2'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop_ok;
            count_q  <= count_q + {1'b0, push} - {1'b0, pop_ok};
        end
    end

    assign valid = count_q != 2'd0;
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fifo_lector.sv
// Pulls bursts out of a show-ahead-less FIFO and streams them downstream with a last marker.
module fifo_lector
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned USE_W = DefUseW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic [USE_W-1:0] burst_len,
    output logic             burst_done,
    output logic             busy,
    fifo_lector_if.master    bus
);

    if (USE_W < $clog2(DEPTH) + 1) begin : gen_bad_use_w
        $error("USE_W is too narrow to hold a full FIFO count");
    end

    lector_state_t    state_q, state_d;
    logic [USE_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [USE_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [USE_W-1:0] eff_len;
    logic             inflight_q, inflight_last_q;
    logic             start, rd_ok, rd_last, pop;
    logic             skid_valid, skid_last;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH:0]   skid_head;
    logic [1:0]       skid_count;
    logic [2:0]       pending;

    assign eff_len = (burst_len == '0) ? USE_W'(1) : burst_len;
    assign start   = (bus.use_dw >= eff_len) || (flush && (bus.use_dw != '0));
    assign pop     = skid_valid && !reset && bus.tx_ready;

    // Words that will sit in the buffer once this cycle's pop and in-flight capture settle.
    assign pending = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, pop};

    assign rd_ok   = (state_q == StLectura) && bus.f_empty_n && (rd_cnt_q < burst_cnt_q) &&
                     (pending < 3'd2) && !reset;
    assign rd_last = rd_ok && ((rd_cnt_q + USE_W'(1)) == burst_cnt_q);

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        burst_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StEspera;
            end
            StEspera: begin
                if (start) begin
                    state_d     = StLectura;
                    burst_cnt_d = (bus.use_dw < eff_len) ? bus.use_dw : eff_len;
                    rd_cnt_d    = '0;
                end else if (!enable) begin
                    state_d = StIdle;
                end
            end
            StLectura: begin
                if (rd_ok) rd_cnt_d = rd_cnt_q + USE_W'(1);
                if (rd_last) state_d = StVaciado;
            end
            StVaciado: begin
                if (pop && skid_last) begin
                    burst_done = 1'b1;
                    state_d    = enable ? StEspera : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= StIdle;
            burst_cnt_q     <= '0;
            rd_cnt_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            burst_cnt_q     <= burst_cnt_d;
            rd_cnt_q        <= rd_cnt_d;
            inflight_q      <= rd_ok;
            inflight_last_q <= rd_last;
        end
    end

    fifo_lector_skid #(
        .WIDTH (WIDTH + 1)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_q),
        .push_data ({inflight_last_q, bus.data_out}),
        .pop       (pop),
        .valid     (skid_valid),
        .head      (skid_head),
        .count     (skid_count)
    );

    assign skid_last = skid_head[WIDTH];
    assign skid_data = skid_head[WIDTH-1:0];

    assign bus.read     = rd_ok;
    assign bus.tx_valid = skid_valid && !reset;
    assign bus.tx_last  = skid_valid && skid_last && !reset;
    assign bus.tx_data  = reset ? '0 : skid_data;
    assign busy         = (state_q != StIdle) && !reset;

endmodule

// File: tb/tb_fifo_lector.sv
// Scoreboard bench for fifo_lector: a FIFO model feeds it, a monitor checks what leaves.
module tb_fifo_lector;
    import fifo_pkg::*;

    localparam int unsigned W  = DefWidth;
    localparam int unsigned UW = DefUseW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic [UW-1:0] burst_len = '0;
    logic          burst_done;
    logic          busy;

    fifo_lector_if #(.WIDTH(W), .USE_W(UW)) bus ();

    fifo_lector #(
        .WIDTH (W),
        .DEPTH (DefDepth),
        .USE_W (UW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .flush      (flush),
        .burst_len  (burst_len),
        .burst_done (burst_done),
        .busy       (busy),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int n_reads = 0;
    int n_acc = 0;
    int t_reads = 0;
    int first_read = -1;
    int last_read = -1;
    int first_valid = -1;

    logic [W-1:0] src_q[$];
    logic [W:0]   exp_q[$];
    logic         toggle_en = 1'b0;
    logic         gate = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W:0]   prev_word = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Source FIFO model: data one cycle after read, count/flag updated at each edge.
    initial begin
        bus.data_out  <= '0;
        bus.use_dw    <= '0;
        bus.f_empty_n <= 1'b0;
        forever begin
            @(posedge clock);
            cyc  <= cyc + 1;
            gate <= ~gate;
            if (reset) begin
                src_q.delete();
                bus.data_out <= '0;
            end else if (bus.read && src_q.size() != 0) begin
                bus.data_out <= src_q.pop_front();
            end
            bus.use_dw    <= UW'(src_q.size());
            bus.f_empty_n <= (src_q.size() != 0) && (!toggle_en || gate);
        end
    end

    // Monitor: samples mid-cycle and compares against the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                n_reads    = 0;
                n_acc      = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk("tx_stable", 32'({bus.tx_valid, bus.tx_last, bus.tx_data}),
                        32'({1'b1, prev_word}));
                if (bus.read) begin
                    n_reads++;
                    t_reads++;
                    if (first_read < 0) first_read = cyc;
                    last_read = cyc;
                    chk("read_gated", 32'(bus.f_empty_n), 32'(1));
                end
                if (bus.tx_valid && first_valid < 0) first_valid = cyc;
                if (bus.tx_valid && bus.tx_ready) begin
                    n_acc++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_word: got 0x%0h, expected no word",
                                 {bus.tx_last, bus.tx_data});
                    end else begin
                        chk("word", 32'({bus.tx_last, bus.tx_data}), 32'(exp_q.pop_front()));
                    end
                end
                if (bus.read) chk("outstanding", 32'((n_reads - n_acc) <= 2), 32'(1));
                if (burst_done || (bus.tx_valid && bus.tx_ready && bus.tx_last)) begin
                    chk("burst_done", 32'(burst_done),
                        32'(bus.tx_valid && bus.tx_ready && bus.tx_last));
                    if (burst_done) done_cnt++;
                end
                prev_stall = bus.tx_valid && !bus.tx_ready;
                prev_word  = {bus.tx_last, bus.tx_data};
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic put(input logic [W-1:0] d, input bit expect_it, input bit last);
        src_q.push_back(d);
        if (expect_it) exp_q.push_back({last, d});
    endtask

    task automatic new_test();
        t_reads     = 0;
        first_read  = -1;
        last_read   = -1;
        first_valid = -1;
    endtask

    task automatic wait_done(input int target, input string name);
        int k = 0;
        while (done_cnt < target && k < 300) begin
            step(1);
            k++;
        end
        if (done_cnt < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: burst_done count %0d, expected %0d", name, done_cnt, target);
        end
    endtask

    initial begin
        int tgt;
        bus.tx_ready = 1'b0;
        enable = 1'b1;
        step(3);
        chk("rst_during", 32'({bus.read, bus.tx_valid, bus.tx_last, burst_done, busy,
                               bus.tx_data}), 32'(0));
        reset = 1'b0;
        #1;
        chk("rst_after", 32'({bus.read, bus.tx_valid, bus.tx_last, burst_done, busy,
                              bus.tx_data}), 32'(0));
        chk("rst_state", 32'(dut.state_q), 32'(StIdle));
        step(2);
        chk("espera_busy", 32'(busy), 32'(1));

        // Threshold burst of 4 at full rate.
        new_test();
        bus.tx_ready = 1'b1;
        burst_len = UW'(4);
        tgt = done_cnt + 1;
        put(8'h11, 1, 0); put(8'h22, 1, 0); put(8'h33, 1, 0); put(8'h44, 1, 1);
        wait_done(tgt, "t1_done");
        chk("t1_reads", 32'(t_reads), 32'(4));
        chk("t1_consecutive", 32'(last_read - first_read), 32'(3));
        chk("t1_latency", 32'(first_valid - first_read), 32'(2));

        // Flush a short burst below the threshold.
        new_test();
        burst_len = UW'(8);
        put(8'hA1, 1, 0); put(8'hA2, 1, 0); put(8'hA3, 1, 1);
        step(4);
        chk("t2_waiting", 32'(dut.state_q), 32'(StEspera));
        tgt = done_cnt + 1;
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        wait_done(tgt, "t2_done");
        chk("t2_reads", 32'(t_reads), 32'(3));
        chk("t2_espera", 32'(dut.state_q), 32'(StEspera));

        // Downstream stall mid-burst, enable dropped meanwhile.
        new_test();
        burst_len = UW'(6);
        tgt = done_cnt + 1;
        put(8'h51, 1, 0); put(8'h52, 1, 0); put(8'h53, 1, 0);
        put(8'h54, 1, 0); put(8'h55, 1, 0); put(8'h56, 1, 1);
        step(4);
        bus.tx_ready = 1'b0;
        enable = 1'b0;
        step(10);
        bus.tx_ready = 1'b1;
        wait_done(tgt, "t3_done");
        chk("t3_reads", 32'(t_reads), 32'(6));
        chk("t3_idle", 32'(busy), 32'(0));
        enable = 1'b1;
        step(2);

        // Not-empty flag toggling every cycle.
        new_test();
        burst_len = UW'(8);
        toggle_en = 1'b1;
        tgt = done_cnt + 1;
        put(8'h81, 1, 0); put(8'h82, 1, 0); put(8'h83, 1, 0); put(8'h84, 1, 0);
        put(8'h85, 1, 0); put(8'h86, 1, 0); put(8'h87, 1, 0); put(8'h88, 1, 1);
        wait_done(tgt, "t4_done");
        toggle_en = 1'b0;
        chk("t4_reads", 32'(t_reads), 32'(8));

        // Zero burst length behaves as one.
        new_test();
        burst_len = '0;
        tgt = done_cnt + 1;
        put(8'h5A, 1, 1);
        wait_done(tgt, "t5_done");
        chk("t5_reads", 32'(t_reads), 32'(1));

        // Reset in the middle of a stalled burst.
        new_test();
        burst_len = UW'(8);
        bus.tx_ready = 1'b0;
        put(8'hC1, 0, 0); put(8'hC2, 0, 0); put(8'hC3, 0, 0); put(8'hC4, 0, 0);
        put(8'hC5, 0, 0); put(8'hC6, 0, 0); put(8'hC7, 0, 0); put(8'hC8, 0, 0);
        step(8);
        chk("t6_lectura", 32'(dut.state_q), 32'(StLectura));
        chk("t6_buffered", 32'(dut.u_skid.count_q), 32'(2));
        reset = 1'b1;
        #1;
        chk("t6_rst_during", 32'({bus.read, bus.tx_valid, busy, bus.tx_data}), 32'(0));
        step(1);
        reset = 1'b0;
        #1;
        chk("t6_rst_after", 32'({bus.read, bus.tx_valid, bus.tx_last, burst_done, busy}),
            32'(0));
        chk("t6_idle", 32'(dut.state_q), 32'(StIdle));
        bus.tx_ready = 1'b1;
        step(5);
        chk("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
